seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side counterpart of the multiplexed 8-digit 7-segment display driver. Samples an external anode-select/segment bus (`an`, `cn`), rejects ghosting at scan transitions, decodes each stable segment pattern back to a BCD digit, and publishes a complete 8-digit frame with a one-cycle strobe. Used as the readback/monitor stage on the receiving board when the clock and stopwatch displays are chained, and as a self-check monitor in system benches.

## Interface
- `STABLE_CYC`, default 16: consecutive identical samples required before a digit is captured (minimum 2).
- `DIGIT_MASK`, default 8'hFF: digits that must be captured to complete a frame. Clock display uses 8'b0011_1111.
- `TIMEOUT_CYC`, default 1_000_000: cycles without any capture before the frame is declared stale.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-low reset.
- `an`  in  8  anode select, active-low one-hot; `an[i]==0` selects digit i, digit 7 leftmost; asynchronous to `clk`.
- `cn`  in  8  segments, active-low; `cn[7:1]`=a..g, `cn[0]`=dp (ignored); asynchronous to `clk`.
- `digits`  out  32  last complete frame; digit i at `[4i+3:4i]`.
- `frame_valid`  out  1  one-cycle pulse when `digits` updates.
- `bad_code`  out  1  one-cycle pulse when an undecodable pattern is captured.
- `stale`  out  1  level; high until the first frame and after a timeout.

## Operation
- `an` and `cn` each pass through a 2-flop synchronizer; decode logic uses only the second stage (`s_an`, `s_cn`).
- Decode of `s_cn[7:1]`:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001101→7, 0000000→8, 0000100→9.
  - 1111111→4'hE (blank).
  - Anything else→4'hF and pulses `bad_code`.
- `s_an` is valid only when exactly one bit is 0.
- FSM states:
  - IDLE: `s_an` invalid (all ones or multi-hot). Enter SETTLE with count=1 on the first valid sample.
  - SETTLE: the count increments while `{s_an,s_cn}` equals the previous sample. Any change restarts SETTLE at count=1, or goes to IDLE if `s_an` becomes invalid. When the count reaches STABLE_CYC: capture, then go to HELD.
  - HELD: capture already done for this dwell. Any change in `{s_an,s_cn}` goes to SETTLE with count=1, or to IDLE if `s_an` is invalid. Exactly one capture occurs per dwell.
- Capture of digit i:
  - Store the decoded value in `shadow[i]` and set `seen[i]`.
  - Recapturing an already-seen digit overwrites it.
  - Captures of digits outside `DIGIT_MASK` are stored but do not count toward completion.
- Frame completion: when `(seen & DIGIT_MASK) == DIGIT_MASK`:
  - Copy `shadow` to `digits`, including the just-captured value. Masked-out positions are forced to 4'hE.
  - Pulse `frame_valid`, clear `seen`, and clear `stale`.
- Timeout counter:
  - Resets on every capture; otherwise increments, saturating.
  - On reaching TIMEOUT_CYC: set `stale`, clear `seen`, leave `digits` unchanged.
- Simultaneous events: completion and timeout in the same cycle resolve as completion (`stale` stays low, counter reset).

## Timing
- Reset values:
  - `digits`=32'hEEEE_EEEE; `frame_valid`=0; `bad_code`=0; `stale`=1.
  - `seen`=0; `shadow`=all 4'hE; FSM=IDLE; counters=0; synchronizers=8'hFF.
- Latency:
  - A pin-level dwell change is seen at `s_an`/`s_cn` after 2 clocks.
  - Capture occurs at the edge where the STABLE_CYC-th identical sample is registered.
  - `frame_valid` and `digits` update on the same edge as the completing capture's register write, so they are visible the next cycle.
  - `bad_code` is asserted in the cycle following the capturing edge.
- A dwell shorter than STABLE_CYC samples produces no capture and no error.
- Reset mid-frame discards `shadow` and `seen`. The first frame after reset requires a fresh capture of every masked digit.

## Test plan
- Clean scan, `STABLE_CYC`=4, `DIGIT_MASK`=8'hFF: drive digits 7..0 with patterns for 1,2,3,4,5,6,7,8, dwell 20 cycles each → one `frame_valid`, `digits`=32'h1234_5678, `stale`=0.
- Ghosting: before each good dwell, insert a 3-cycle wrong pattern → no extra captures, no `bad_code`, same `digits`.
- Masked clock frame, `DIGIT_MASK`=8'b0011_1111: scan only digits 5..0 showing 2,3,5,9,5,9 → `digits`=32'hEE23_5959.
- Invalid code: digit 3 shows 8'b1010_1010 → one `bad_code` pulse; next frame has nibble 3 = 4'hF.
- Timeout, `TIMEOUT_CYC`=64: after one frame, hold `an`=8'hFF for 70 cycles → `stale`=1 at cycle 64, `digits` unchanged. Resume scan → `stale` clears with the next `frame_valid`.
- Reset mid-frame: capture digits 7..4, pulse `rst` low for 1 cycle, then scan 3..0 only → no `frame_valid`, and all outputs equal their reset values.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Monitor for a multiplexed 8-digit active-low 7-segment bus: synchronizes the pins,
// waits for a stable dwell per digit, decodes it, and publishes complete frames.
module seg_scan_decoder #(
    parameter int          STABLE_CYC  = 16,
    parameter logic [7:0]  DIGIT_MASK  = 8'hFF,
    parameter int          TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an,
    input  logic [7:0]  cn,
    output logic [31:0] digits,
    output logic        frame_valid,
    output logic        bad_code,
    output logic        stale
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STABLE_CYC);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    logic [7:0]       r_an_meta;
    logic [7:0]       r_an_sync;
    logic [7:0]       r_cn_meta;
    logic [7:0]       r_cn_sync;
    logic [15:0]      r_prev;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_capture;
    logic [TO_W-1:0]  r_to_cnt;
    logic [3:0]       r_shadow [8];
    logic [7:0]       r_seen;
    logic [7:0]       w_seen_nxt;
    logic             w_complete;
    logic [31:0]      w_frame;
    logic             w_an_valid;
    logic             w_same;
    logic [2:0]       w_idx;
    logic [3:0]       w_dec;
    logic             w_dec_bad;

    // Exactly one low bit in an active-low one-hot select.
    function automatic logic onehot_low(input logic [7:0] v);
        logic [7:0] inv;
        inv = ~v;
        return (inv != 8'h00) && ((inv & (inv - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [2:0] low_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Returns {bad, value}; segments a..g are active-low.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b0000001: res = {1'b0, 4'h0};
            7'b1001111: res = {1'b0, 4'h1};
            7'b0010010: res = {1'b0, 4'h2};
            7'b0000110: res = {1'b0, 4'h3};
            7'b1001100: res = {1'b0, 4'h4};
            7'b0100100: res = {1'b0, 4'h5};
            7'b0100000: res = {1'b0, 4'h6};
            7'b0001101: res = {1'b0, 4'h7};
            7'b0000000: res = {1'b0, 4'h8};
            7'b0000100: res = {1'b0, 4'h9};
            7'b1111111: res = {1'b0, 4'hE};
            default:    res = {1'b1, 4'hF};
        endcase
        return res;
    endfunction

    assign w_an_valid           = onehot_low(r_an_sync);
    assign w_same               = ({r_an_sync, r_cn_sync} == r_prev);
    assign w_idx                = low_index(r_an_sync);
    assign {w_dec_bad, w_dec}   = seg_decode(r_cn_sync[7:1]);
    assign w_seen_nxt           = r_seen | (8'b0000_0001 << w_idx);
    assign w_complete           = ((w_seen_nxt & DIGIT_MASK) == DIGIT_MASK);

    // Two-flop synchronizers plus the previous-sample register used for stability.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_an_meta <= 8'hFF;
            r_an_sync <= 8'hFF;
            r_cn_meta <= 8'hFF;
            r_cn_sync <= 8'hFF;
            r_prev    <= 16'hFFFF;
        end else begin
            r_an_meta <= an;
            r_an_sync <= r_an_meta;
            r_cn_meta <= cn;
            r_cn_sync <= r_cn_meta;
            r_prev    <= {r_an_sync, r_cn_sync};
        end
    end

    // Dwell FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Dwell FSM next state: one capture per stable dwell, ghosts restart the count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_an_valid) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            end
            ST_SETTLE: begin
                if (w_same && (r_cnt == CNT_LAST)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = CNT_FULL;
                end else if (w_same) begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end else if (w_an_valid) begin
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            end
            ST_HELD: begin
                if (w_same) begin
                    w_state_nxt = ST_HELD;
                end else if (w_an_valid) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Frame image: the just-captured value bypasses the shadow, unmasked digits read blank.
    always_comb begin
        w_frame = 32'hEEEE_EEEE;
        for (int i = 0; i < 8; i++) begin
            if (!DIGIT_MASK[i]) begin
                w_frame[4*i +: 4] = 4'hE;
            end else if (3'(i) == w_idx) begin
                w_frame[4*i +: 4] = w_dec;
            end else begin
                w_frame[4*i +: 4] = r_shadow[i];
            end
        end
    end

    // Capture, frame publication and staleness timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            digits      <= 32'hEEEE_EEEE;
            frame_valid <= 1'b0;
            bad_code    <= 1'b0;
            stale       <= 1'b1;
            r_seen      <= 8'h00;
            r_to_cnt    <= {TO_W{1'b0}};
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= 4'hE;
            end
        end else begin
            frame_valid <= 1'b0;
            bad_code    <= 1'b0;
            if (w_capture) begin
                r_shadow[w_idx] <= w_dec;
                bad_code        <= w_dec_bad;
                r_to_cnt        <= {TO_W{1'b0}};
                if (w_complete) begin
                    digits      <= w_frame;
                    frame_valid <= 1'b1;
                    stale       <= 1'b0;
                    r_seen      <= 8'h00;
                end else begin
                    r_seen      <= w_seen_nxt;
                end
            end else if (r_to_cnt != TO_MAX) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
                if (r_to_cnt == (TO_MAX - TO_W'(1))) begin
                    stale  <= 1'b1;
                    r_seen <= 8'h00;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench: expected frames are queued as scans are driven and checked on frame_valid.
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  an_a, cn_a, an_b, cn_b;
    logic [31:0] digits_a, digits_b;
    logic        fv_a, fv_b, bc_a, bc_b, stale_a, stale_b;

    int checks   = 0;
    int failures = 0;
    int frames_a = 0;
    int frames_b = 0;
    int bads_a   = 0;
    int bads_b   = 0;
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];

    seg_scan_decoder #(.STABLE_CYC(4), .DIGIT_MASK(8'hFF), .TIMEOUT_CYC(64)) u_dut_a (
        .clk(clk), .rst(rst), .an(an_a), .cn(cn_a),
        .digits(digits_a), .frame_valid(fv_a), .bad_code(bc_a), .stale(stale_a)
    );

    seg_scan_decoder #(.STABLE_CYC(4), .DIGIT_MASK(8'b0011_1111), .TIMEOUT_CYC(64)) u_dut_b (
        .clk(clk), .rst(rst), .an(an_b), .cn(cn_b),
        .digits(digits_b), .frame_valid(fv_b), .bad_code(bc_b), .stale(stale_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] seg(input logic [3:0] d);
        case (d)
            4'h0: return {7'b0000001, 1'b1};
            4'h1: return {7'b1001111, 1'b1};
            4'h2: return {7'b0010010, 1'b1};
            4'h3: return {7'b0000110, 1'b1};
            4'h4: return {7'b1001100, 1'b1};
            4'h5: return {7'b0100100, 1'b1};
            4'h6: return {7'b0100000, 1'b1};
            4'h7: return {7'b0001101, 1'b1};
            4'h8: return {7'b0000000, 1'b1};
            4'h9: return {7'b0000100, 1'b1};
            default: return 8'hFF;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b1 && fv_a === 1'b1) begin
            frames_a++;
            checks++;
            if (exp_a.size() == 0) begin
                failures++;
                $display("FAIL frame_a_unexpected got=%h expected=none", digits_a);
            end else begin
                logic [31:0] e;
                e = exp_a.pop_front();
                if (digits_a !== e) begin
                    failures++;
                    $display("FAIL frame_a_digits got=%h expected=%h", digits_a, e);
                end
            end
        end
        if (rst === 1'b1 && fv_b === 1'b1) begin
            frames_b++;
            checks++;
            if (exp_b.size() == 0) begin
                failures++;
                $display("FAIL frame_b_unexpected got=%h expected=none", digits_b);
            end else begin
                logic [31:0] e;
                e = exp_b.pop_front();
                if (digits_b !== e) begin
                    failures++;
                    $display("FAIL frame_b_digits got=%h expected=%h", digits_b, e);
                end
            end
        end
        if (rst === 1'b1 && bc_a === 1'b1) bads_a++;
        if (rst === 1'b1 && bc_b === 1'b1) bads_b++;
    end

    task automatic drive_a(input int idx, input logic [7:0] pat, input int cyc);
        @(negedge clk);
        an_a = ~(8'b0000_0001 << idx);
        cn_a = pat;
        repeat (cyc - 1) @(negedge clk);
    endtask

    task automatic drive_b(input int idx, input logic [7:0] pat, input int cyc);
        @(negedge clk);
        an_b = ~(8'b0000_0001 << idx);
        cn_b = pat;
        repeat (cyc - 1) @(negedge clk);
    endtask

    // Scan digits hi..lo of DUT A; optional 3-cycle ghost before each dwell, optional corrupt digit.
    task automatic scan_a(input logic [31:0] val, input int hi, input int lo,
                          input bit ghost, input int bad_pos);
        for (int i = hi; i >= lo; i--) begin
            if (ghost) drive_a(i, 8'b1010_1010, 3);
            if (i == bad_pos) drive_a(i, 8'b1010_1010, 20);
            else              drive_a(i, seg(val[4*i +: 4]), 20);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 8;
        if (digits_a !== 32'hEEEE_EEEE) begin failures++; $display("FAIL reset_digits_a got=%h expected=eeeeeeee", digits_a); end
        if (fv_a !== 1'b0)    begin failures++; $display("FAIL reset_fv_a got=%b expected=0", fv_a); end
        if (bc_a !== 1'b0)    begin failures++; $display("FAIL reset_bc_a got=%b expected=0", bc_a); end
        if (stale_a !== 1'b1) begin failures++; $display("FAIL reset_stale_a got=%b expected=1", stale_a); end
        if (digits_b !== 32'hEEEE_EEEE) begin failures++; $display("FAIL reset_digits_b got=%h expected=eeeeeeee", digits_b); end
        if (fv_b !== 1'b0)    begin failures++; $display("FAIL reset_fv_b got=%b expected=0", fv_b); end
        if (bc_b !== 1'b0)    begin failures++; $display("FAIL reset_bc_b got=%b expected=0", bc_b); end
        if (stale_b !== 1'b1) begin failures++; $display("FAIL reset_stale_b got=%b expected=1", stale_b); end
    endtask

    task automatic test_clean_scan;
        int f0, b0;
        f0 = frames_a; b0 = bads_a;
        exp_a.push_back(32'h1234_5678);
        scan_a(32'h1234_5678, 7, 0, 1'b0, -1);
        for (int k = 0; k < 100 && exp_a.size() != 0; k++) @(negedge clk);
        checks += 3;
        if (frames_a - f0 !== 1) begin failures++; $display("FAIL clean_frames got=%0d expected=1", frames_a - f0); end
        if (stale_a !== 1'b0)    begin failures++; $display("FAIL clean_stale got=%b expected=0", stale_a); end
        if (bads_a - b0 !== 0)   begin failures++; $display("FAIL clean_bad got=%0d expected=0", bads_a - b0); end
    endtask

    task automatic test_ghosting;
        int f0, b0;
        f0 = frames_a; b0 = bads_a;
        exp_a.push_back(32'h1234_5678);
        scan_a(32'h1234_5678, 7, 0, 1'b1, -1);
        for (int k = 0; k < 100 && exp_a.size() != 0; k++) @(negedge clk);
        checks += 2;
        if (frames_a - f0 !== 1) begin failures++; $display("FAIL ghost_frames got=%0d expected=1", frames_a - f0); end
        if (bads_a - b0 !== 0)   begin failures++; $display("FAIL ghost_bad got=%0d expected=0", bads_a - b0); end
    endtask

    task automatic test_invalid_code;
        int f0, b0;
        f0 = frames_a; b0 = bads_a;
        exp_a.push_back(32'h1234_F678);
        scan_a(32'h1234_5678, 7, 0, 1'b0, 3);
        for (int k = 0; k < 100 && exp_a.size() != 0; k++) @(negedge clk);
        checks += 2;
        if (frames_a - f0 !== 1) begin failures++; $display("FAIL invalid_frames got=%0d expected=1", frames_a - f0); end
        if (bads_a - b0 !== 1)   begin failures++; $display("FAIL invalid_bad got=%0d expected=1", bads_a - b0); end
    endtask

    task automatic test_timeout;
        int f0;
        @(negedge clk);
        an_a = 8'hFF;
        cn_a = 8'hFF;
        repeat (30) @(negedge clk);
        checks++;
        if (stale_a !== 1'b0) begin failures++; $display("FAIL timeout_early_stale got=%b expected=0", stale_a); end
        repeat (40) @(negedge clk);
        checks += 2;
        if (stale_a !== 1'b1) begin failures++; $display("FAIL timeout_stale got=%b expected=1", stale_a); end
        if (digits_a !== 32'h1234_F678) begin failures++; $display("FAIL timeout_digits got=%h expected=1234f678", digits_a); end
        f0 = frames_a;
        exp_a.push_back(32'h8765_4321);
        scan_a(32'h8765_4321, 7, 0, 1'b0, -1);
        for (int k = 0; k < 100 && exp_a.size() != 0; k++) @(negedge clk);
        checks += 2;
        if (frames_a - f0 !== 1) begin failures++; $display("FAIL resume_frames got=%0d expected=1", frames_a - f0); end
        if (stale_a !== 1'b0)    begin failures++; $display("FAIL resume_stale got=%b expected=0", stale_a); end
        @(negedge clk);
        an_a = 8'hFF;
    endtask

    task automatic test_masked_clock;
        int f0;
        logic [31:0] shown;
        shown = 32'h0023_5959;
        f0 = frames_b;
        exp_b.push_back(32'hEE23_5959);
        for (int i = 5; i >= 0; i--) drive_b(i, seg(shown[4*i +: 4]), 20);
        for (int k = 0; k < 100 && exp_b.size() != 0; k++) @(negedge clk);
        checks += 3;
        if (frames_b - f0 !== 1) begin failures++; $display("FAIL masked_frames got=%0d expected=1", frames_b - f0); end
        if (stale_b !== 1'b0)    begin failures++; $display("FAIL masked_stale got=%b expected=0", stale_b); end
        if (bads_b !== 0)        begin failures++; $display("FAIL masked_bad got=%0d expected=0", bads_b); end
        @(negedge clk);
        an_b = 8'hFF;
    endtask

    task automatic test_reset_mid_frame;
        int f0;
        f0 = frames_a;
        scan_a(32'h8765_4321, 7, 4, 1'b0, -1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        scan_a(32'h8765_4321, 3, 0, 1'b0, -1);
        repeat (10) @(negedge clk);
        checks += 6;
        if (frames_a - f0 !== 0) begin failures++; $display("FAIL midrst_frames got=%0d expected=0", frames_a - f0); end
        if (digits_a !== 32'hEEEE_EEEE) begin failures++; $display("FAIL midrst_digits_a got=%h expected=eeeeeeee", digits_a); end
        if (fv_a !== 1'b0)    begin failures++; $display("FAIL midrst_fv got=%b expected=0", fv_a); end
        if (bc_a !== 1'b0)    begin failures++; $display("FAIL midrst_bc got=%b expected=0", bc_a); end
        if (stale_a !== 1'b1) begin failures++; $display("FAIL midrst_stale got=%b expected=1", stale_a); end
        if (digits_b !== 32'hEEEE_EEEE) begin failures++; $display("FAIL midrst_digits_b got=%h expected=eeeeeeee", digits_b); end
        @(negedge clk);
        an_a = 8'hFF;
    endtask

    initial begin
        rst  = 1'b0;
        an_a = 8'hFF; cn_a = 8'hFF;
        an_b = 8'hFF; cn_b = 8'hFF;
        test_reset();
        test_clean_scan();
        test_ghosting();
        test_invalid_code();
        test_timeout();
        test_masked_clock();
        test_reset_mid_frame();
        checks += 2;
        if (exp_a.size() !== 0) begin failures++; $display("FAIL pending_a got=%0d expected=0", exp_a.size()); end
        if (exp_b.size() !== 0) begin failures++; $display("FAIL pending_b got=%0d expected=0", exp_b.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
